// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_pkg
// Brief  : Shared UART constants for data width, FIFO depth and frame timing.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_BIT_TICKS  = 16;
  localparam int UART_FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_fifo_mem
// Brief  : DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  // Contents are don't-care after reset, so the array carries no reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : uart_rx_fifo
// Brief  : First-word-fall-through receive FIFO with level/flag/overflow
//          status. Define UART_RX_TIMEOUT_EN to add the idle-data timeout.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int AF_THRESH = 12
`ifdef UART_RX_TIMEOUT_EN
  ,
  parameter int TO_CHARS  = 4
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [UART_DATA_W-1:0]   wr_data,
  input  logic                     wr_stb,
  input  logic                     rd_ready,
  input  logic                     ovf_clr,
`ifdef UART_RX_TIMEOUT_EN
  input  logic                     baud_tick_16x,
  output logic                     timeout,
`endif
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] c_ptr_one   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   c_lvl_one   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   c_depth     = DEPTH[AW:0];
  localparam logic [AW:0]   c_af_thresh = AF_THRESH[AW:0];

  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_level;
  logic                   r_rd_valid;
  logic                   r_full;
  logic                   r_empty;
  logic                   r_almost_full;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic [AW:0]            w_level_nxt;
  logic [UART_DATA_W-1:0] w_mem_rdata;

  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_pop  = r_rd_valid & rd_ready;
  assign w_push = wr_stb & (~r_full | w_pop);
  assign w_drop = wr_stb & r_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + c_lvl_one;
      2'b01:   w_level_nxt = r_level - c_lvl_one;
      default: w_level_nxt = r_level;
    endcase
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_rd_valid    <= 1'b0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      // Flags come from the next level so they stay aligned with the pointers.
      r_level       <= w_level_nxt;
      r_rd_valid    <= (w_level_nxt != '0);
      r_empty       <= (w_level_nxt == '0);
      r_full        <= (w_level_nxt == c_depth);
      r_almost_full <= (w_level_nxt >= c_af_thresh);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign rd_data     = r_rd_valid ? w_mem_rdata : '0;
  assign rd_valid    = r_rd_valid;
  assign level       = r_level;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TO_CHARS * UART_BIT_TICKS * UART_FRAME_BITS;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [TW-1:0] c_to_limit = TO_LIMIT[TW-1:0];
  localparam logic [TW-1:0] c_to_one   = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] r_idle_cnt;
  logic          r_timeout;

  // Counter saturates at the limit; any FIFO activity or emptiness restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_push || w_pop || r_empty) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (baud_tick_16x && (r_idle_cnt != c_to_limit)) begin
      r_idle_cnt <= r_idle_cnt + c_to_one;
      if (r_idle_cnt == (c_to_limit - c_to_one)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_uart_rx_fifo
// Brief  : Self-checking bench for uart_rx_fifo (vector table, directed
//          corner sequences, randomized scoreboard run).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic       rd_ready;
  logic       ovf_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
`ifdef UART_RX_TIMEOUT_EN
  logic       baud_tick_16x;
  logic       timeout;
`endif

  int total;
  int passed;

  uart_rx_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_data       (wr_data),
    .wr_stb        (wr_stb),
    .rd_ready      (rd_ready),
    .ovf_clr       (ovf_clr),
`ifdef UART_RX_TIMEOUT_EN
    .baud_tick_16x (baud_tick_16x),
    .timeout       (timeout),
`endif
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .level         (level),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       ovf_clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] pack_status(input logic v, input logic [7:0] d,
                                              input logic [4:0] l, input logic f,
                                              input logic e, input logic af);
    return {v, d, l, f, e, af};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] d, input logic r, input logic c);
    wr_stb   = s;
    wr_data  = d;
    rd_ready = r;
    ovf_clr  = c;
  endtask

  logic [7:0] q[$];
  logic [7:0] pop_exp[16];
  logic       m_ovf;

  initial begin
    total    = 0;
    passed   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_TIMEOUT_EN
    baud_tick_16x = 1'b0;
`endif
    cycle();
    cycle();
    check("reset_status", {16'h0, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
          {16'h0, pack_status(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0)});
    check("reset_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;

    // {wr_stb, wr_data, rd_ready, ovf_clr, valid, data, level, full, empty, af, ovf}
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].wr_stb, vecs[i].wr_data, vecs[i].rd_ready, vecs[i].ovf_clr);
      cycle();
      check($sformatf("vec%0d", i),
            {15'h0, overflow, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
            {15'h0, vecs[i].exp_ovf, pack_status(vecs[i].exp_valid, vecs[i].exp_data,
             vecs[i].exp_level, vecs[i].exp_full, vecs[i].exp_empty, vecs[i].exp_af)});
    end

    // Fill to full with no reads.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      cycle();
      check($sformatf("fill%0d", i),
            {16'h0, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
            {16'h0, pack_status(1'b1, 8'h00, 5'(i + 1), (i == 15), 1'b0, (i + 1 >= 12))});
    end

    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle();
    check("ovf_set", {15'h0, overflow, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
          {15'h0, 1'b1, pack_status(1'b1, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1)});
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    cycle();
    check("ovf_set_wins", {31'h0, overflow}, 32'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cycle();
    check("ovf_clear", {31'h0, overflow}, 32'h0);

    drive(1'b1, 8'h55, 1'b1, 1'b0);
    cycle();
    check("full_push_pop", {16'h0, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
          {16'h0, pack_status(1'b1, 8'h01, 5'd16, 1'b1, 1'b0, 1'b1)});

    for (int k = 0; k < 15; k++) pop_exp[k] = 8'(k + 1);
    pop_exp[15] = 8'h55;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("drain%0d", k), {23'h0, rd_valid, rd_data}, {23'h0, 1'b1, pop_exp[k]});
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("drained_empty", {16'h0, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
          {16'h0, pack_status(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0)});

    // Randomized run against a queue model, with a reset in the middle.
    q.delete();
    m_ovf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit         s, r, clr, pop, push, drop;
      logic [7:0] d;
      int         ph;
      ph  = (c / 400) % 2;
      s   = ($urandom_range(0, 99) < (ph ? 80 : 30));
      r   = ($urandom_range(0, 99) < (ph ? 30 : 80));
      clr = ($urandom_range(0, 63) == 0);
      d   = 8'($urandom_range(0, 255));
      if (c == 5000) begin
        rst_n = 1'b0;
        drive(s, d, r, clr);
        cycle();
        rst_n = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        check("midstream_reset", {15'h0, overflow, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
              {15'h0, 1'b0, pack_status(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0)});
        continue;
      end
      pop  = (q.size() != 0) && r;
      push = s && ((q.size() < 16) || pop);
      drop = s && (q.size() == 16) && !pop;
      drive(s, d, r, clr);
      cycle();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      check($sformatf("rand%0d", c),
            {15'h0, overflow, pack_status(rd_valid, rd_data, level, full, empty, almost_full)},
            {15'h0, m_ovf, pack_status(q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
             5'(q.size()), q.size() == 16, q.size() == 0, q.size() >= 12)});
    end

`ifdef UART_RX_TIMEOUT_EN
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    cycle();
    rst_n = 1'b1;
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    baud_tick_16x = 1'b1;
    for (int t = 0; t < 639; t++) cycle();
    check("timeout_639", {31'h0, timeout}, 32'h0);
    cycle();
    check("timeout_640", {31'h0, timeout}, 32'h1);
    baud_tick_16x = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("timeout_pop", {31'h0, timeout}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
